// File: rtl/collision_scorer.sv
// -----------------------------------------------------------------------------
// collision_scorer
//
// Sits downstream of the dino jump-height generator. Once per video frame it
// checks whether the obstacle overlaps the dino hitbox while the dino is too
// low to clear it. After HIT_FRAMES consecutive hit frames it declares a
// collision: it raises halt (freezing the jump generator and scroller) and
// pulses game_over. It also keeps a saturating 4-digit BCD score of obstacles
// cleared, and runs the press-then-release restart handshake that ends in a
// one-cycle game_reset pulse.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   frame_tick  one-cycle pulse per video frame; game evaluation happens here
//   jumpaddr    dino height above ground (pixels)
//   obs_x       obstacle left edge column
//   obs_h       obstacle height above ground
//   obs_valid   obstacle present on screen
//   button      jump button, already synchronised to clk
//   halt        high while the game is frozen (HALTED / RELEASE)
//   game_over   one-cycle pulse when a collision is declared
//   game_reset  one-cycle pulse restarting the downstream game logic
//   score       four BCD digits, score[3:0] = units
// -----------------------------------------------------------------------------
module collision_scorer #(
  parameter int DINO_X_L   = 40,
  parameter int DINO_X_R   = 60,
  parameter int OBS_W      = 16,
  parameter int HIT_FRAMES = 2,
  parameter int X_W        = 10,
  parameter int Y_W        = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic [Y_W-1:0] jumpaddr,
  input  logic [X_W-1:0] obs_x,
  input  logic [Y_W-1:0] obs_h,
  input  logic           obs_valid,
  input  logic           button,
  output logic           halt,
  output logic           game_over,
  output logic           game_reset,
  output logic [15:0]    score
);

  localparam int CNT_W = (HIT_FRAMES < 2) ? 1 : $clog2(HIT_FRAMES + 1);

  // hit_cnt value on the tick that completes the required run of hit frames
  localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'(HIT_FRAMES - 1);
  localparam logic [X_W-1:0]   X_RIGHT   = X_W'(DINO_X_R);
  localparam logic [X_W:0]     X_LEFT    = (X_W + 1)'(DINO_X_L);
  localparam logic [X_W:0]     OBS_W_EXT = (X_W + 1)'(OBS_W);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
  logic             prev_ovl_reg, prev_ovl_next;
  logic [15:0]      score_reg, score_next;
  logic             game_over_reg, game_over_next;
  logic             game_reset_reg, game_reset_next;

  // ---------------------------------------------------------------------------
  // Frame evaluation terms
  // ---------------------------------------------------------------------------
  logic [X_W:0] obs_right_ext;
  logic         ovl;
  logic         low;
  logic         hit;
  logic         collide;
  logic         clear;
  logic         score_max;
  logic [15:0]  score_inc;

  // One extra bit so an obstacle near the right screen edge cannot wrap
  // around and look like it sits left of the dino.
  assign obs_right_ext = {1'b0, obs_x} + OBS_W_EXT;

  assign ovl     = obs_valid && (obs_x <= X_RIGHT) && (obs_right_ext > X_LEFT);
  assign low     = (jumpaddr < obs_h);
  assign hit     = ovl && low;
  assign collide = hit && (hit_cnt_reg == HIT_LAST);

  // An obstacle is cleared on the frame it stops overlapping, provided it is
  // still on screen; a collision on the same frame suppresses the point.
  assign clear     = prev_ovl_reg && !ovl && obs_valid && !collide;
  assign score_max = (score_reg == 16'h9999);

  // ---------------------------------------------------------------------------
  // BCD +1 with ripple carry between digits
  // ---------------------------------------------------------------------------
  logic [3:0] carry;
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit = score_reg[4*gi +: 4];

      assign score_inc[4*gi +: 4] = !carry[gi]      ? digit :
                                    (digit == 4'd9) ? 4'd0  :
                                                      digit + 4'd1;
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit == 4'd9);
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    hit_cnt_next    = hit_cnt_reg;
    prev_ovl_next   = prev_ovl_reg;
    score_next      = score_reg;
    game_over_next  = 1'b0;
    game_reset_next = 1'b0;

    case (state_reg)
      RUN: begin
        if (frame_tick) begin
          prev_ovl_next = ovl;
          if (collide) begin
            state_next     = HALTED;
            hit_cnt_next   = '0;
            game_over_next = 1'b1;
          end else if (hit) begin
            hit_cnt_next = hit_cnt_reg + CNT_W'(1);
          end else begin
            hit_cnt_next = '0;
          end
          if (clear && !score_max) begin
            score_next = score_inc;
          end
        end
      end

      HALTED: begin
        if (button) begin
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        // Restart only after the button is let go, so the press that
        // acknowledged game over cannot also start the next game.
        if (!button) begin
          state_next      = RUN;
          game_reset_next = 1'b1;
          score_next      = '0;
          hit_cnt_next    = '0;
          prev_ovl_next   = 1'b0;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      hit_cnt_reg    <= '0;
      prev_ovl_reg   <= 1'b0;
      score_reg      <= '0;
      game_over_reg  <= 1'b0;
      game_reset_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hit_cnt_reg    <= hit_cnt_next;
      prev_ovl_reg   <= prev_ovl_next;
      score_reg      <= score_next;
      game_over_reg  <= game_over_next;
      game_reset_reg <= game_reset_next;
    end
  end

  // halt follows the state register directly, so it drops in the same cycle
  // that game_reset is high.
  assign halt       = (state_reg != RUN);
  assign game_over  = game_over_reg;
  assign game_reset = game_reset_reg;
  assign score      = score_reg;

endmodule
